// File: rtl/ir_prefetch_dispatch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ir_prefetch_dispatch_if : fetch/IR/dispatch bus for ir_prefetch_dispatch   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ir_prefetch_dispatch_if #(
    parameter int DEPTH   = 4,
    parameter int IR_W    = 13,
    parameter int DRAM_W  = 15,
    parameter int DRAM_AW = 9
);
    localparam int CW = $clog2(DEPTH + 1);

    logic               wrValid;
    logic               wrReady;
    logic [0:IR_W-1]    wrData;
    logic               flush;
    logic               loadIR;
    logic               busy;
    logic               irValid;
    logic [0:IR_W-1]    IR;
    logic [0:3]         AC;
    logic               jrst0;
    logic [0:DRAM_AW-1] dramAddr;
    logic [0:DRAM_W-1]  dramData;
    logic               dramValid;
    logic [0:2]         dramA;
    logic [0:2]         dramB;
    logic [0:3]         dramJ;
    logic               dramParErr;
    logic               cfgWr;
    logic [1:0]         cfgData;
    logic [CW-1:0]      count;

    modport master (
        output wrValid, wrData, flush, loadIR, dramData, cfgWr, cfgData,
        input  wrReady, busy, irValid, IR, AC, jrst0, dramAddr, dramValid,
               dramA, dramB, dramJ, dramParErr, count
    );

    modport slave (
        input  wrValid, wrData, flush, loadIR, dramData, cfgWr, cfgData,
        output wrReady, busy, irValid, IR, AC, jrst0, dramAddr, dramValid,
               dramA, dramB, dramJ, dramParErr, count
    );
endinterface
`default_nettype wire

// File: rtl/ir_prefetch_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ir_prefetch_dispatch : prefetch queue -> IR/AC -> 2-cycle DRAM dispatch    |
// | Optional diagnostic read port enabled by macro IR_DIAG_EN.   Rev 1.0       |
// +----------------------------------------------------------------------------+
module ir_prefetch_dispatch #(
    parameter int DEPTH   = 4,
    parameter int IR_W    = 13,
    parameter int DRAM_W  = 15,
    parameter int DRAM_AW = 9
) (
    input  wire logic             clk,
    input  wire logic             reset,
    ir_prefetch_dispatch_if.slave bus
`ifdef IR_DIAG_EN
    ,
    input  wire logic [2:0]       diagSel,
    input  wire logic             diagRd,
    output wire logic [0:5]       diagData
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    logic [0:IR_W-1]    mem_q [DEPTH];
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               wrReady_q;
    state_t             state_q;
    logic               busy_q, irValid_q, dramValid_q, parErr_q;
    logic [0:IR_W-1]    ir_q;
    logic [0:3]         ac_q;
    logic [0:DRAM_AW-1] dramAddr_q;
    logic [0:2]         dramA_q, dramB_q;
    logic [0:3]         dramJ_q;
    logic               enIO_q, enAC_q;

    logic               w_push, w_pop, w_jrst0;
    logic [0:IR_W-1]    w_head;
    logic [0:8]         w_addr;

    assign w_push  = bus.wrValid & wrReady_q;
    assign w_pop   = bus.loadIR & (count_q != '0) & (state_q == S_IDLE);
    assign w_head  = mem_q[rptr_q];
    assign count_d = count_q + CW'(w_push) - CW'(w_pop);
    assign w_jrst0 = (ir_q[0:8] == 9'o254) && (ir_q[9:12] == 4'd0);

    // I/O opcodes fold the device field into a compact 0o7xx dispatch region.
    always_comb begin
        w_addr = w_head[0:8];
        if (enIO_q && (w_head[0:2] == 3'b111))
            w_addr = {3'b111, w_head[7:9] | {3{&w_head[3:6]}}, w_head[10:12]};
    end

    always_ff @(posedge clk) begin
        if (w_push && !bus.flush)
            mem_q[wptr_q] <= bus.wrData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            wrReady_q   <= 1'b1;
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            irValid_q   <= 1'b0;
            dramValid_q <= 1'b0;
            parErr_q    <= 1'b0;
            ir_q        <= '0;
            ac_q        <= '0;
            dramAddr_q  <= '0;
            dramA_q     <= '0;
            dramB_q     <= '0;
            dramJ_q     <= '0;
            enIO_q      <= 1'b0;
            enAC_q      <= 1'b0;
        end else begin
            if (bus.cfgWr)
                {enIO_q, enAC_q} <= bus.cfgData;
            if (bus.flush) begin
                wptr_q      <= '0;
                rptr_q      <= '0;
                count_q     <= '0;
                wrReady_q   <= 1'b1;
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                irValid_q   <= 1'b0;
                dramValid_q <= 1'b0;
                parErr_q    <= 1'b0;
            end else begin
                wptr_q    <= wptr_q + PW'(w_push);
                rptr_q    <= rptr_q + PW'(w_pop);
                count_q   <= count_d;
                wrReady_q <= (count_d != CW'(DEPTH));
                case (state_q)
                    S_IDLE: begin
                        if (w_pop) begin
                            ir_q        <= w_head;
                            ac_q        <= enAC_q ? w_head[9:12] : 4'd0;
                            irValid_q   <= 1'b1;
                            dramValid_q <= 1'b0;
                            dramAddr_q  <= DRAM_AW'(w_addr);
                            busy_q      <= 1'b1;
                            state_q     <= S_ADDR;
                        end
                    end
                    S_ADDR: state_q <= S_LATCH;
                    S_LATCH: begin
                        dramA_q     <= bus.dramData[0:2];
                        dramB_q     <= bus.dramData[3:5];
                        // JRST dispatches on its AC field instead of the DRAM J bits.
                        dramJ_q     <= (ir_q[0:8] == 9'o254) ? ir_q[9:12] : bus.dramData[7:10];
                        parErr_q    <= parErr_q | ~^bus.dramData;
                        dramValid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.wrReady    = wrReady_q;
    assign bus.busy       = busy_q;
    assign bus.irValid    = irValid_q;
    assign bus.IR         = ir_q;
    assign bus.AC         = ac_q;
    assign bus.jrst0      = w_jrst0;
    assign bus.dramAddr   = dramAddr_q;
    assign bus.dramValid  = dramValid_q;
    assign bus.dramA      = dramA_q;
    assign bus.dramB      = dramB_q;
    assign bus.dramJ      = dramJ_q;
    assign bus.dramParErr = parErr_q;
    assign bus.count      = count_q;

`ifdef IR_DIAG_EN
    logic [0:5] w_diag;
    logic [2:0] w_cnt3;
    assign w_cnt3 = 3'(count_q);

    always_comb begin
        w_diag = '0;
        case (diagSel)
            3'd0:    w_diag = {w_cnt3, dramAddr_q[0:2]};
            3'd1:    w_diag = dramAddr_q[3:8];
            3'd2:    w_diag = {enIO_q, enAC_q, ac_q};
            3'd3:    w_diag = {dramA_q, dramB_q};
            3'd4:    w_diag = {dramValid_q, w_jrst0, dramJ_q};
            3'd5:    w_diag = {parErr_q, irValid_q, busy_q, 2'(state_q), wrReady_q};
            default: w_diag = '0;
        endcase
    end

    assign diagData = diagRd ? w_diag : 'z;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ir_prefetch_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ir_prefetch_dispatch : randomized bench with queue-based reference model|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ir_prefetch_dispatch;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ir_prefetch_dispatch_if #(.DEPTH(DEPTH), .IR_W(13), .DRAM_W(15), .DRAM_AW(9)) bus ();

`ifdef IR_DIAG_EN
    logic [2:0] diagSel = 3'd0;
    logic       diagRd  = 1'b0;
    wire  [0:5] diagData;
`endif

    ir_prefetch_dispatch #(.DEPTH(DEPTH), .IR_W(13), .DRAM_W(15), .DRAM_AW(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IR_DIAG_EN
        ,
        .diagSel  (diagSel),
        .diagRd   (diagRd),
        .diagData (diagData)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Synchronous dispatch RAM contents (value numbering: bit 14 = DRAM bit 0)
    logic [14:0] dram_mem [512];
    logic [8:0]  dram_prev;

    // Reference model: words held LSB-numbered (bit 12 = IR bit 0)
    logic [12:0] m_q[$];
    bit          m_enIO, m_enAC, m_irv, m_dv, m_perr;
    logic [12:0] m_ir;
    logic [3:0]  m_ac, m_j;
    logic [2:0]  m_a, m_b;
    logic [8:0]  m_addr;
    int          m_age;  // cycles since the in-flight pop; 0 when none

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [8:0] dispatch_addr(input logic [12:0] w, input bit en_io);
        if (en_io && w[12:10] == 3'b111)
            return {3'b111, w[5:3] | {3{&w[9:6]}}, w[2:0]};
        return w[12:4];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_enIO = 0; m_enAC = 0; m_irv = 0; m_dv = 0; m_perr = 0;
        m_ir = '0; m_ac = '0; m_j = '0; m_a = '0; m_b = '0; m_addr = '0; m_age = 0;
    endtask

    task automatic model_step(input bit v, input logic [12:0] d, input bit fl,
                              input bit ld, input bit cw, input logic [1:0] cd);
        int          sz;
        bit          push, pop;
        logic [14:0] dd;
        logic [12:0] w;
        sz   = m_q.size();
        push = v && (sz < DEPTH);
        pop  = ld && (sz > 0) && (m_age == 0);
        if (fl) begin
            m_q.delete(); m_irv = 0; m_dv = 0; m_perr = 0; m_age = 0;
        end else begin
            if (m_age == 2) begin
                dd = dram_mem[m_addr];
                m_a = dd[14:12];
                m_b = dd[11:9];
                m_j = (m_ir[12:4] == 9'o254) ? m_ir[3:0] : dd[7:4];
                m_perr = m_perr | ~^dd;
                m_dv = 1; m_age = 0;
            end else if (m_age == 1) begin
                m_age = 2;
            end
            if (pop) begin
                w = m_q.pop_front();
                m_ir = w;
                m_ac = m_enAC ? w[3:0] : 4'd0;
                m_irv = 1; m_dv = 0;
                m_addr = dispatch_addr(w, m_enIO);
                m_age = 1;
            end
            if (push) m_q.push_back(d);
        end
        if (cw) {m_enIO, m_enAC} = cd;
    endtask

    task automatic compare();
        chk("count",      int'(bus.count),      m_q.size());
        chk("wrReady",    int'(bus.wrReady),    int'(m_q.size() < DEPTH));
        chk("busy",       int'(bus.busy),       int'(m_age != 0));
        chk("irValid",    int'(bus.irValid),    int'(m_irv));
        chk("IR",         int'(bus.IR),         int'(m_ir));
        chk("AC",         int'(bus.AC),         int'(m_ac));
        chk("jrst0",      int'(bus.jrst0),      int'(m_ir == {9'o254, 4'd0}));
        chk("dramAddr",   int'(bus.dramAddr),   int'(m_addr));
        chk("dramValid",  int'(bus.dramValid),  int'(m_dv));
        chk("dramA",      int'(bus.dramA),      int'(m_a));
        chk("dramB",      int'(bus.dramB),      int'(m_b));
        chk("dramJ",      int'(bus.dramJ),      int'(m_j));
        chk("dramParErr", int'(bus.dramParErr), int'(m_perr));
    endtask

    // Drive one cycle at the falling edge, then check after the next rising edge.
    task automatic cycle(input bit v, input logic [12:0] d, input bit fl,
                         input bit ld, input bit cw, input logic [1:0] cd);
        bus.wrValid = v; bus.wrData = d; bus.flush = fl;
        bus.loadIR = ld; bus.cfgWr = cw; bus.cfgData = cd;
        model_step(v, d, fl, ld, cw, cd);
        @(posedge clk);
        @(negedge clk);
        bus.dramData = dram_mem[dram_prev];
        dram_prev    = 9'(bus.dramAddr);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0, 2'b00);
    endtask

    localparam logic [12:0] W0 = {9'o020, 4'hF};
    localparam logic [12:0] W1 = {9'o254, 4'd7};
    localparam logic [12:0] W2 = {9'o254, 4'd0};
    localparam logic [12:0] W3 = {3'b111, 4'hF, 3'b010, 3'b100};

    initial begin
        for (int i = 0; i < 512; i++) dram_mem[i] = 15'($urandom);
        dram_mem[9'o020] = 15'o12345;
        bus.wrValid = 0; bus.wrData = '0; bus.flush = 0; bus.loadIR = 0;
        bus.cfgWr = 0; bus.cfgData = '0; bus.dramData = '0;
        dram_prev = '0;
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare();
        chk("rst_wrReady", int'(bus.wrReady), 1);
        chk("rst_count",   int'(bus.count),   0);

        // Fill to capacity; the fifth word must be refused.
        cycle(0, '0, 0, 0, 1, 2'b01);
        cycle(1, W0, 0, 0, 0, 2'b00);
        cycle(1, W1, 0, 0, 0, 2'b00);
        cycle(1, W2, 0, 0, 0, 2'b00);
        cycle(1, W3, 0, 0, 0, 2'b00);
        cycle(1, 13'o17777, 0, 0, 0, 2'b00);
        chk("full_count",   int'(bus.count),   4);
        chk("full_wrReady", int'(bus.wrReady), 0);

        cycle(0, '0, 0, 1, 0, 2'b00);
        chk("pop_IR",       int'(bus.IR),       13'h10F);
        chk("pop_AC",       int'(bus.AC),       15);
        chk("pop_busy",     int'(bus.busy),     1);
        chk("pop_dramAddr", int'(bus.dramAddr), 9'o020);
        idle(1);
        chk("lat_dramValid", int'(bus.dramValid), 0);
        idle(1);
        chk("lat3_dramValid", int'(bus.dramValid), 1);
        chk("lat3_A",         int'(bus.dramA),      1);
        chk("lat3_B",         int'(bus.dramB),      2);
        chk("lat3_J",         int'(bus.dramJ),      14);
        chk("lat3_parErr",    int'(bus.dramParErr), 0);

        cycle(0, '0, 0, 1, 0, 2'b00);
        idle(2);
        chk("jrst_J",     int'(bus.dramJ), 7);
        chk("jrst_jrst0", int'(bus.jrst0), 0);
        cycle(0, '0, 0, 1, 0, 2'b00);
        chk("jrst0_set",  int'(bus.jrst0), 1);
        idle(2);

        cycle(0, '0, 0, 0, 1, 2'b11);
        cycle(0, '0, 0, 1, 0, 2'b00);
        chk("io_dramAddr", int'(bus.dramAddr), 9'o774);
        idle(2);
        chk("drained_count", int'(bus.count), 0);
        cycle(1, W3, 0, 0, 1, 2'b01);
        cycle(0, '0, 0, 1, 0, 2'b00);
        chk("noio_dramAddr", int'(bus.dramAddr), 9'o775);
        idle(2);

        // Flush while a lookup sits in its latch cycle with two words still queued.
        for (int i = 0; i < 3; i++) cycle(1, 13'($urandom), 0, 0, 0, 2'b00);
        cycle(0, '0, 0, 1, 0, 2'b00);
        idle(1);
        chk("preflush_count", int'(bus.count), 2);
        cycle(0, '0, 1, 0, 0, 2'b00);
        chk("flush_count",     int'(bus.count),     0);
        chk("flush_irValid",   int'(bus.irValid),   0);
        chk("flush_dramValid", int'(bus.dramValid), 0);

        // Sustained push+pop traffic to wrap the pointers several times.
        for (int i = 0; i < 3; i++) cycle(1, 13'($urandom), 0, 0, 0, 2'b00);
        for (int i = 0; i < 30; i++) cycle(1, 13'($urandom), 0, 1, 0, 2'b00);

        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 10) < 7, 13'($urandom), ($urandom % 50) == 0,
                  ($urandom % 2) == 1, ($urandom % 20) == 0, 2'($urandom));

        // Asynchronous reset while a lookup is in flight.
        idle(2);
        cycle(1, W0, 0, 0, 0, 2'b00);
        cycle(1, W1, 0, 1, 0, 2'b00);
        reset = 1'b1;
        #1;
        chk("arst_busy",    int'(bus.busy),    0);
        chk("arst_irValid", int'(bus.irValid), 0);
        chk("arst_count",   int'(bus.count),   0);
        chk("arst_IR",      int'(bus.IR),      0);
        model_reset();
        dram_prev = '0;
        @(negedge clk);
        reset = 1'b0;
        compare();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
